alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 64-bit `alu` instance between two requesters, e.g. two issue slots or an execute unit and a CSR/address unit.
- Arbitrates with round-robin over valid/ready request channels.
- Drives the ALU operand and op inputs, registers the result, and returns it on one tagged response channel with backpressure.
- Rejects illegal (non-one-hot) op codes without touching the ALU.

Parameters:
DW, 64, operand/result width (matches alu)
OPW, 12, one-hot op width (matches alu_op)
TAGW, 4, requester-supplied tag width returned with result
CNTW, 32, width of per-requester accepted-op counters

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle when valid&ready
req0_op  in  OPW  one-hot ALU op
req0_src1  in  DW  operand 1
req0_src2  in  DW  operand 2
req0_tag  in  TAGW  tag echoed on response
req1_valid, req1_ready, req1_op, req1_src1, req1_src2, req1_tag  same as req0, for requester 1
alu_op  out  OPW  to alu.alu_op
alu_src1  out  DW  to alu.alu_src1
alu_src2  out  DW  to alu.alu_src2
alu_result  in  DW  from alu.alu_result (combinational)
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer takes response when valid&ready
rsp_id  out  1  requester index of response
rsp_tag  out  TAGW  tag of response
rsp_result  out  DW  registered ALU result
rsp_err  out  1  op was not one-hot; rsp_result forced 0
acc_cnt0  out  CNTW  ops accepted from requester 0
acc_cnt1  out  CNTW  ops accepted from requester 1

Behaviour:
- Reset (async assert, sync release) clears all state:
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_err=0.
  - acc_cnt0=acc_cnt1=0.
  - last_grant=1, so requester 0 wins the first contention.
- can_issue = !rsp_valid | rsp_ready. It combinationally depends on rsp_ready, which gives single-entry buffering at full throughput.
- Grant (combinational), only when can_issue:
  - Only one req valid: that one is granted.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- reqN_ready = can_issue & grant==N. Ready never asserts for a non-granted requester. Ready may depend on valid; requesters must not make valid depend on ready.
- ALU drive:
  - On grant with a legal op: alu_op/src1/src2 = granted request's fields.
  - Otherwise (no grant, or illegal op): alu_op=0, alu_src1=0, alu_src2=0.
- Legal op: exactly one bit set in the OPW-bit op. 0 and multi-hot are illegal.
- On accept (valid&ready), at the next clk edge:
  - rsp_valid<=1, rsp_id<=N, rsp_tag<=tag.
  - rsp_result<=alu_result, or 0 if illegal; rsp_err<=illegal.
  - last_grant<=N.
  - acc_cntN<=acc_cntN+1, wrapping modulo 2^CNTW. Illegal ops are counted too.
- Latency: accept in cycle T gives rsp_valid in cycle T+1.
- Throughput: 1 op/cycle while rsp_ready=1.
- Response draining:
  - rsp_valid&rsp_ready with no new accept in the same cycle: rsp_valid<=0. Other rsp fields hold their last value.
  - Drain and accept in the same cycle: the new result replaces the old one; rsp_valid stays 1.
- Backpressure: while rsp_valid&!rsp_ready, all rsp_* fields hold stable and both reqN_ready=0.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1.
- last_grant updates only on an accept.
- Reset mid-operation: any in-flight response is dropped, counters clear, and arbitration restarts with requester 0 priority.

Test Plan:
- Single op: req0 op=12'd1 (add), src1=288, src2=77, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_tag=3, rsp_result=365, rsp_err=0, acc_cnt0=1.
- Contention: both valid for 4 cycles, req0 op=12'd2 288-77, req1 op=12'd1 288+(-77):
  - responses alternate id 0,1,0,1;
  - results 211 and 211;
  - acc_cnt0=acc_cnt1=2.
- Backpressure: rsp_ready=0 with an accepted result pending -> rsp_* stable for 3 cycles, req0_ready=req1_ready=0. Raise rsp_ready with req1 valid -> drain and the next accept occur in the same cycle, no bubble.
- Illegal op: req1 op=12'h003 -> alu_op=0, rsp_err=1, rsp_result=0, acc_cnt1 increments. Next legal op returns rsp_err=0.
- Idle: no valid -> alu_op=0, alu_src1=alu_src2=0. After a drain, rsp_valid falls to 0.
- Reset mid-stream: assert resetn=0 while rsp_valid=1 under contention -> rsp_valid=0 and counters 0 immediately. After release, req0 is granted first when both are valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters
// and returns each result on a single tagged, back-pressured response register.
module alu_arbiter #(
  parameter int DW   = 64,
  parameter int OPW  = 12,
  parameter int TAGW = 4,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            resetn,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [DW-1:0]   req0_src1,
  input  logic [DW-1:0]   req0_src2,
  input  logic [TAGW-1:0] req0_tag,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [DW-1:0]   req1_src1,
  input  logic [DW-1:0]   req1_src2,
  input  logic [TAGW-1:0] req1_tag,

  output logic [OPW-1:0]  alu_op,
  output logic [DW-1:0]   alu_src1,
  output logic [DW-1:0]   alu_src2,
  input  logic [DW-1:0]   alu_result,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [TAGW-1:0] rsp_tag,
  output logic [DW-1:0]   rsp_result,
  output logic            rsp_err,

  output logic [CNTW-1:0] acc_cnt0,
  output logic [CNTW-1:0] acc_cnt1
);

  logic            lastGrant_q, lastGrant_d;
  logic            rspValid_q,  rspValid_d;
  logic            rspId_q,     rspId_d;
  logic [TAGW-1:0] rspTag_q,    rspTag_d;
  logic [DW-1:0]   rspResult_q, rspResult_d;
  logic            rspErr_q,    rspErr_d;
  logic [CNTW-1:0] accCnt0_q,   accCnt0_d;
  logic [CNTW-1:0] accCnt1_q,   accCnt1_d;

  logic            canIssue;
  logic            grantValid;
  logic            grantId;
  logic            opLegal;
  logic            driveAlu;
  logic [OPW-1:0]  selOp;
  logic [DW-1:0]   selSrc1;
  logic [DW-1:0]   selSrc2;
  logic [TAGW-1:0] selTag;

  function automatic logic isOneHot(input logic [OPW-1:0] op);
    return (op != '0) && ((op & (op - OPW'(1))) == '0);
  endfunction

  // A drain in the same cycle frees the register, so issue never bubbles.
  assign canIssue = !rspValid_q || rsp_ready;

  always_comb begin
    grantValid = 1'b0;
    grantId    = 1'b0;
    if (canIssue) begin
      if (req0_valid && req1_valid) begin
        grantValid = 1'b1;
        grantId    = ~lastGrant_q;
      end else if (req0_valid) begin
        grantValid = 1'b1;
        grantId    = 1'b0;
      end else if (req1_valid) begin
        grantValid = 1'b1;
        grantId    = 1'b1;
      end
    end
  end

  assign req0_ready = grantValid && (grantId == 1'b0);
  assign req1_ready = grantValid && (grantId == 1'b1);

  always_comb begin
    selOp   = req0_op;
    selSrc1 = req0_src1;
    selSrc2 = req0_src2;
    selTag  = req0_tag;
    if (grantId) begin
      selOp   = req1_op;
      selSrc1 = req1_src1;
      selSrc2 = req1_src2;
      selTag  = req1_tag;
    end
  end

  assign opLegal  = isOneHot(selOp);
  assign driveAlu = grantValid && opLegal;

  // Illegal ops and idle cycles present all-zero inputs so the ALU stays quiet.
  assign alu_op   = driveAlu ? selOp   : '0;
  assign alu_src1 = driveAlu ? selSrc1 : '0;
  assign alu_src2 = driveAlu ? selSrc2 : '0;

  always_comb begin
    lastGrant_d = lastGrant_q;
    rspValid_d  = rspValid_q;
    rspId_d     = rspId_q;
    rspTag_d    = rspTag_q;
    rspResult_d = rspResult_q;
    rspErr_d    = rspErr_q;
    accCnt0_d   = accCnt0_q;
    accCnt1_d   = accCnt1_q;
    if (grantValid) begin
      rspValid_d  = 1'b1;
      rspId_d     = grantId;
      rspTag_d    = selTag;
      rspResult_d = opLegal ? alu_result : '0;
      rspErr_d    = !opLegal;
      lastGrant_d = grantId;
      if (grantId) begin
        accCnt1_d = accCnt1_q + CNTW'(1);
      end else begin
        accCnt0_d = accCnt0_q + CNTW'(1);
      end
    end else if (rspValid_q && rsp_ready) begin
      rspValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lastGrant_q <= 1'b1;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspTag_q    <= '0;
      rspResult_q <= '0;
      rspErr_q    <= 1'b0;
      accCnt0_q   <= '0;
      accCnt1_q   <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspTag_q    <= rspTag_d;
      rspResult_q <= rspResult_d;
      rspErr_q    <= rspErr_d;
      accCnt0_q   <= accCnt0_d;
      accCnt1_q   <= accCnt1_d;
    end
  end

  assign rsp_valid  = rspValid_q;
  assign rsp_id     = rspId_q;
  assign rsp_tag    = rspTag_q;
  assign rsp_result = rspResult_q;
  assign rsp_err    = rspErr_q;
  assign acc_cnt0   = accCnt0_q;
  assign acc_cnt1   = accCnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU feeds the DUT and a small
// arbitration model predicts grants, ALU drive and every response.
module tb_alu_arbiter;

  logic        clk;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [11:0] req0_op, req1_op;
  logic [63:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_tag, req1_tag;
  logic [11:0] alu_op;
  logic [63:0] alu_src1, alu_src2, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0]  rsp_tag;
  logic [63:0] rsp_result;
  logic [31:0] acc_cnt0, acc_cnt1;

  typedef struct {
    bit          id;
    logic [3:0]  tag;
    logic [63:0] result;
    bit          err;
  } expRsp_t;

  expRsp_t     expQ[$];
  bit          modelLastGrant;
  logic [31:0] modelCnt0, modelCnt1;
  int          errors;
  int          checks;

  alu_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] aluFunc(input logic [11:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return a << b[5:0];
      12'h008: return a ^ b;
      12'h010: return a | b;
      12'h020: return a & b;
      default: return {a[31:0], b[31:0]};
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  assign alu_result = aluFunc(alu_op, alu_src1, alu_src2);

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    modelLastGrant = 1'b1;
    modelCnt0      = '0;
    modelCnt1      = '0;
  endtask

  // One clock cycle: drive after the edge, check and advance the model at the falling edge.
  task automatic applyStimulus(
    input bit v0, input logic [11:0] op0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] t0,
    input bit v1, input logic [11:0] op1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] t1,
    input bit rr);
    bit          canIssue, gv, gid, legal;
    logic [11:0] sOp;
    logic [63:0] sA, sB;
    logic [3:0]  sT;
    expRsp_t     e;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_op = op0; req0_src1 = a0; req0_src2 = b0; req0_tag = t0;
    req1_valid = v1; req1_op = op1; req1_src1 = a1; req1_src2 = b1; req1_tag = t1;
    rsp_ready  = rr;
    @(negedge clk);
    if (expQ.size() > 0) begin
      checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("rsp_id", 64'(rsp_id), 64'(expQ[0].id));
      checkOutput("rsp_tag", 64'(rsp_tag), 64'(expQ[0].tag));
      checkOutput("rsp_result", rsp_result, expQ[0].result);
      checkOutput("rsp_err", 64'(rsp_err), 64'(expQ[0].err));
    end else begin
      checkOutput("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    checkOutput("acc_cnt0", 64'(acc_cnt0), 64'(modelCnt0));
    checkOutput("acc_cnt1", 64'(acc_cnt1), 64'(modelCnt1));

    canIssue = (expQ.size() == 0) || rr;
    gv  = canIssue && (v0 || v1);
    gid = (v0 && v1) ? !modelLastGrant : !v0;
    checkOutput("req0_ready", 64'(req0_ready), 64'(gv && !gid));
    checkOutput("req1_ready", 64'(req1_ready), 64'(gv && gid));

    sOp = gid ? op1 : op0;
    sA  = gid ? a1 : a0;
    sB  = gid ? b1 : b0;
    sT  = gid ? t1 : t0;
    legal = ($countones(sOp) == 1);
    checkOutput("alu_op", 64'(alu_op), (gv && legal) ? 64'(sOp) : 64'd0);
    checkOutput("alu_src1", alu_src1, (gv && legal) ? sA : 64'd0);
    checkOutput("alu_src2", alu_src2, (gv && legal) ? sB : 64'd0);

    if (expQ.size() > 0 && rr) void'(expQ.pop_front());
    if (gv) begin
      e.id     = gid;
      e.tag    = sT;
      e.result = legal ? aluFunc(sOp, sA, sB) : 64'd0;
      e.err    = !legal;
      expQ.push_back(e);
      modelLastGrant = gid;
      if (gid) modelCnt1 = modelCnt1 + 32'd1;
      else     modelCnt0 = modelCnt0 + 32'd1;
    end
  endtask

  task automatic idleCycle(input bit rr);
    applyStimulus(0, 12'h0, 64'd0, 64'd0, 4'd0, 0, 12'h0, 64'd0, 64'd0, 4'd0, rr);
  endtask

  task automatic bothCycle(input bit rr);
    applyStimulus(1, 12'h002, 64'd288, 64'd77, 4'd1, 1, 12'h001, 64'd288, 64'(-77), 4'd2, rr);
  endtask

  task automatic checkResetState();
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    checkOutput("rst_rsp_result", rsp_result, 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_acc_cnt0", 64'(acc_cnt0), 64'd0);
    checkOutput("rst_acc_cnt1", 64'(acc_cnt1), 64'd0);
  endtask

  initial begin
    logic [11:0] opList [8];
    errors = 0;
    checks = 0;
    opList[0] = 12'h001; opList[1] = 12'h002; opList[2] = 12'h004; opList[3] = 12'h008;
    opList[4] = 12'h010; opList[5] = 12'h020; opList[6] = 12'h000; opList[7] = 12'h081;
    resetn = 1'b0;
    req0_valid = 0; req0_op = '0; req0_src1 = '0; req0_src2 = '0; req0_tag = '0;
    req1_valid = 0; req1_op = '0; req1_src1 = '0; req1_src2 = '0; req1_tag = '0;
    rsp_ready  = 1'b1;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    resetn = 1'b1;

    // Single op on requester 0, then let it drain.
    applyStimulus(1, 12'h001, 64'd288, 64'd77, 4'd3, 0, 12'h0, 64'd0, 64'd0, 4'd0, 1);
    idleCycle(1);
    checkOutput("single_result", rsp_result, 64'd365);
    idleCycle(1);

    // Contention: both requesters valid for four cycles.
    repeat (4) bothCycle(1);
    idleCycle(1);
    idleCycle(1);
    checkOutput("contention_cnt0", 64'(acc_cnt0), 64'd3);
    checkOutput("contention_cnt1", 64'(acc_cnt1), 64'd2);

    // Backpressure: hold three cycles, then drain and accept in one cycle.
    bothCycle(1);
    repeat (3) bothCycle(0);
    applyStimulus(0, 12'h0, 64'd0, 64'd0, 4'd0, 1, 12'h008, 64'hF0F0, 64'h0FF0, 4'd9, 1);
    idleCycle(1);
    idleCycle(1);

    // Illegal multi-hot op, followed by a legal op from the same requester.
    applyStimulus(0, 12'h0, 64'd0, 64'd0, 4'd0, 1, 12'h003, 64'd5, 64'd6, 4'd5, 1);
    applyStimulus(0, 12'h0, 64'd0, 64'd0, 4'd0, 1, 12'h001, 64'd5, 64'd6, 4'd6, 1);
    idleCycle(1);
    idleCycle(1);

    // Randomised traffic with random backpressure and occasional illegal ops.
    for (int i = 0; i < 80; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, opList[$urandom_range(0, 7)],
                    {$urandom, $urandom}, 64'($urandom_range(0, 70)), 4'($urandom),
                    $urandom_range(0, 1) == 1, opList[$urandom_range(0, 7)],
                    {$urandom, $urandom}, 64'($urandom_range(0, 70)), 4'($urandom),
                    $urandom_range(0, 3) != 0);
    end

    // Reset while a response is pending under contention.
    bothCycle(1);
    bothCycle(0);
    #2;
    resetn = 1'b0;
    req0_valid = 0;
    req1_valid = 0;
    #1;
    checkResetState();
    clearModel();
    @(negedge clk);
    resetn = 1'b1;
    bothCycle(1);
    checkOutput("post_reset_req0_first", 64'(req0_ready), 64'd1);
    bothCycle(1);
    idleCycle(1);
    idleCycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
